// File: rtl/cmp_rgb_exerciser.sv
// Sweeps every operand pair into a magnitude comparator, checks its RGB indicator,
// counts mismatches and records the first failing vector.
module cmp_rgb_exerciser #(
  parameter int unsigned WIDTH       = 2,
  parameter int unsigned HOLD_CYCLES = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic [WIDTH-1:0]   a_out,
  output logic [WIDTH-1:0]   b_out,
  input  logic               red_in,
  input  logic               green_in,
  input  logic               blue_in,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [2*WIDTH:0]   err_count,
  output logic               fail_valid,
  output logic [WIDTH-1:0]   fail_a,
  output logic [WIDTH-1:0]   fail_b,
  output logic [2:0]         fail_rgb
);

  localparam int unsigned IW = 2 * WIDTH;
  localparam int unsigned EW = IW + 1;
  localparam int unsigned HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  localparam logic [IW-1:0] LAST_IDX  = {IW{1'b1}};
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [EW-1:0] ERR_MAX   = {EW{1'b1}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state, state_n;
  logic [IW-1:0]   idx, idx_n;
  logic [HW-1:0]   hold_cnt, hold_cnt_n;
  logic            busy_n, done_n, pass_n;
  logic [EW-1:0]   err_count_n;
  logic            fail_valid_n;
  logic [WIDTH-1:0] fail_a_n, fail_b_n;
  logic [2:0]      fail_rgb_n;

  logic [WIDTH-1:0] cur_a, cur_b;
  logic [2:0]       sample, expected;
  logic             mismatch;

  // Operands come straight from the registered vector index
  assign cur_a = idx[IW-1:WIDTH];
  assign cur_b = idx[WIDTH-1:0];
  assign a_out = cur_a;
  assign b_out = cur_b;

  // One-hot colour the comparator should show for the current vector
  always_comb begin
    sample   = {red_in, green_in, blue_in};
    expected = 3'b001;
    if (cur_a > cur_b)       expected = 3'b100;
    else if (cur_a == cur_b) expected = 3'b010;
    mismatch = (sample != expected);
  end

  // Sweep sequencing, checking and result capture
  always_comb begin
    state_n      = state;
    idx_n        = idx;
    hold_cnt_n   = hold_cnt;
    busy_n       = busy;
    done_n       = done;
    pass_n       = pass;
    err_count_n  = err_count;
    fail_valid_n = fail_valid;
    fail_a_n     = fail_a;
    fail_b_n     = fail_b;
    fail_rgb_n   = fail_rgb;

    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_n      = DRIVE;
          idx_n        = '0;
          hold_cnt_n   = '0;
          busy_n       = 1'b1;
          done_n       = 1'b0;
          pass_n       = 1'b0;
          err_count_n  = '0;
          fail_valid_n = 1'b0;
          fail_a_n     = '0;
          fail_b_n     = '0;
          fail_rgb_n   = '0;
        end
      end
      DRIVE: begin
        if (hold_cnt == HOLD_LAST) begin
          if (mismatch) begin
            if (err_count != ERR_MAX) err_count_n = err_count + EW'(1);
            if (!fail_valid) begin
              fail_valid_n = 1'b1;
              fail_a_n     = cur_a;
              fail_b_n     = cur_b;
              fail_rgb_n   = sample;
            end
          end
          if (idx == LAST_IDX) begin
            state_n = DONE;
            busy_n  = 1'b0;
            done_n  = 1'b1;
            pass_n  = (err_count_n == '0);
          end else begin
            idx_n      = idx + IW'(1);
            hold_cnt_n = '0;
          end
        end else begin
          hold_cnt_n = hold_cnt + HW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State and result registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= '0;
      hold_cnt   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
      fail_valid <= 1'b0;
      fail_a     <= '0;
      fail_b     <= '0;
      fail_rgb   <= '0;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      hold_cnt   <= hold_cnt_n;
      busy       <= busy_n;
      done       <= done_n;
      pass       <= pass_n;
      err_count  <= err_count_n;
      fail_valid <= fail_valid_n;
      fail_a     <= fail_a_n;
      fail_b     <= fail_b_n;
      fail_rgb   <= fail_rgb_n;
    end
  end

endmodule
